// File: rtl/fir_accum_round.sv
// Accumulates signed 48-bit partials into per-sample 52-bit sums, then rounds, scales, saturates and holds each result for a ready/valid consumer.
// Define FIR_ACC_CONVERGENT_EN to round exact ties to the even quotient instead of rounding half up.
module fir_accum_round #(
  parameter int OW    = 24,
  parameter int SHIFT = 17
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          CE,
  input  logic [47:0]   P,
  input  logic          PV,
  input  logic          PLAST,
  output logic [OW-1:0] Y,
  output logic          YV,
  input  logic          YRDY,
  output logic          OVF,
  output logic          LOST,
  output logic          ERR,
  input  logic          CLRF
);

  localparam logic [52:0]        HALF  = 53'd1 << (SHIFT - 1);
  localparam logic signed [52:0] Y_MAX = (53'sd1 <<< (OW - 1)) - 53'sd1;
  localparam logic signed [52:0] Y_MIN = -(53'sd1 <<< (OW - 1));

  logic signed [51:0] acc_q, acc_d;
  logic        [3:0]  cnt_q, cnt_d;
  logic               done_q, done_d;
  logic signed [52:0] s2_q, s2_d;
  logic               s2v_q, s2v_d;
  logic      [OW-1:0] s3_q, s3_d;
  logic               s3v_q, s3v_d;
  logic      [OW-1:0] y_q, y_d;
  logic               yv_q, yv_d;
  logic               ovf_q, ovf_d, lost_q, lost_d, err_q, err_d;
  logic               ovf_set, lost_set, err_set, last;
  logic signed [51:0] p_ext;
  logic signed [52:0] rnd;
`ifdef FIR_ACC_CONVERGENT_EN
  localparam logic [52:0] FRAC_MASK = (53'd1 << SHIFT) - 53'd1;
  logic tie;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_set = 1'b0;
    last    = 1'b0;
    p_ext   = {{4{P[47]}}, P};
    if (PV) begin
      last    = PLAST || (cnt_q == 4'hF);
      acc_d   = (cnt_q == 4'd0) ? p_ext : acc_q + p_ext;
      cnt_d   = last ? 4'd0 : cnt_q + 4'd1;
      done_d  = last;
      err_set = !PLAST && (cnt_q == 4'hF);
    end

    // Stage 2: add half an LSB of the scaled result, then floor-shift.
    rnd   = {acc_q[51], acc_q} + HALF;
    s2_d  = s2_q;
    s2v_d = done_q;
`ifdef FIR_ACC_CONVERGENT_EN
    tie = ({acc_q[51], acc_q} & FRAC_MASK) == HALF;
`endif
    if (done_q) begin
      s2_d = rnd >>> SHIFT;
`ifdef FIR_ACC_CONVERGENT_EN
      if (tie) s2_d[0] = 1'b0;
`endif
    end

    // Stage 3: clamp into the signed OW-bit output range.
    s3_d    = s3_q;
    s3v_d   = s2v_q;
    ovf_set = 1'b0;
    if (s2v_q) begin
      if (s2_q > Y_MAX) begin
        s3_d    = {1'b0, {(OW-1){1'b1}}};
        ovf_set = 1'b1;
      end else if (s2_q < Y_MIN) begin
        s3_d    = {1'b1, {(OW-1){1'b0}}};
        ovf_set = 1'b1;
      end else begin
        s3_d = s2_q[OW-1:0];
      end
    end

    // A held result is never overwritten; a result arriving behind it is dropped.
    y_d      = y_q;
    yv_d     = yv_q;
    lost_set = 1'b0;
    if (yv_q && YRDY) yv_d = 1'b0;
    if (s3v_q) begin
      if (!yv_q || YRDY) begin
        y_d  = s3_q;
        yv_d = 1'b1;
      end else begin
        lost_set = 1'b1;
      end
    end

    ovf_d  = !CLRF && (ovf_q  || ovf_set);
    lost_d = !CLRF && (lost_q || lost_set);
    err_d  = !CLRF && (err_q  || err_set);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      s2_q   <= '0;
      s2v_q  <= 1'b0;
      s3_q   <= '0;
      s3v_q  <= 1'b0;
      y_q    <= '0;
      yv_q   <= 1'b0;
      ovf_q  <= 1'b0;
      lost_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (CE) begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      s2_q   <= s2_d;
      s2v_q  <= s2v_d;
      s3_q   <= s3_d;
      s3v_q  <= s3v_d;
      y_q    <= y_d;
      yv_q   <= yv_d;
      ovf_q  <= ovf_d;
      lost_q <= lost_d;
      err_q  <= err_d;
    end
  end

  assign Y    = y_q;
  assign YV   = yv_q;
  assign OVF  = ovf_q;
  assign LOST = lost_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_fir_accum_round.sv
// Scoreboard bench for fir_accum_round: an arithmetic reference model predicts each sample, a monitor checks every output transfer.
module tb_fir_accum_round;
  localparam int OW    = 24;
  localparam int SHIFT = 17;
`ifdef FIR_ACC_CONVERGENT_EN
  localparam logic [OW-1:0] TIE_HALF = 0;
`else
  localparam logic [OW-1:0] TIE_HALF = 1;
`endif

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0, CE = 1'b1, PV = 1'b0, PLAST = 1'b0, YRDY = 1'b1, CLRF = 1'b0;
  logic [47:0]   P = '0;
  logic [OW-1:0] Y;
  logic          YV, OVF, LOST, ERR;

  int n_tests = 0;
  int n_fail  = 0;
  logic [OW-1:0] exp_q[$];
  longint samp_sum = 0;
  int     samp_cnt = 0;
  bit     model_ovf = 0, model_err = 0;

  always #5 CLK = ~CLK;

  fir_accum_round #(.OW(OW), .SHIFT(SHIFT)) dut (
    .CLK(CLK), .RSTN(RSTN), .CE(CE), .P(P), .PV(PV), .PLAST(PLAST),
    .Y(Y), .YV(YV), .YRDY(YRDY), .OVF(OVF), .LOST(LOST), .ERR(ERR), .CLRF(CLRF)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    longint q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Reference: scaled value = floor((sum + 2^(SHIFT-1)) / 2^SHIFT), optional tie-to-even, then clamp.
  function automatic logic [OW-1:0] ref_out(input longint s, output bit clamped);
    longint scale = 64'sd1 <<< SHIFT;
    longint half  = scale / 2;
    longint hi    = (64'sd1 <<< (OW - 1)) - 1;
    longint lo    = -(64'sd1 <<< (OW - 1));
    longint q     = fdiv(s + half, scale);
`ifdef FIR_ACC_CONVERGENT_EN
    if ((s - fdiv(s, scale) * scale == half) && (q % 2 != 0)) q = q - 1;
`endif
    clamped = 0;
    if (q > hi) begin q = hi; clamped = 1; end
    else if (q < lo) begin q = lo; clamped = 1; end
    return q[OW-1:0];
  endfunction

  task automatic model_partial(input longint v, input bit last);
    bit c;
    samp_sum = (samp_cnt == 0) ? v : samp_sum + v;
    samp_cnt++;
    if (last || samp_cnt == 16) begin
      exp_q.push_back(ref_out(samp_sum, c));
      if (c) model_ovf = 1;
      if (!last) model_err = 1;
      samp_cnt = 0;
    end
  endtask

  // Present one partial and hold it until an edge with CE=1 has taken it.
  task automatic send(input longint v, input bit last, input bit ce_rand);
    bit took;
    P = v[47:0]; PV = 1'b1; PLAST = last;
    model_partial(v, last);
    do begin
      CE = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      took = CE;
      @(posedge CLK); #1;
    end while (!took);
    PV = 1'b0; PLAST = 1'b0; CE = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic pulse_clrf();
    CLRF = 1'b1; @(posedge CLK); #1; CLRF = 1'b0;
    model_ovf = 0; model_err = 0;
  endtask

  task automatic wait_y(input string name, input logic [OW-1:0] e);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (YV) seen = 1;
    end
    check({name, "_yv"}, longint'(seen), 1);
    check(name, longint'(Y), longint'(e));
    @(posedge CLK); #1;
  endtask

  task automatic drain(input string name, input bit rand_rdy);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      if (rand_rdy) YRDY = $urandom_range(0, 1);
      @(posedge CLK); #1;
    end
    YRDY = 1'b1;
    check(name, longint'(exp_q.size()), 0);
  endtask

  function automatic longint rand_p();
    longint v = {$urandom, $urandom};
    case ($urandom_range(0, 4))
      0: v = v >>> 44;
      1: v = v >>> 34;
      2: v = v >>> 24;
      3: v = v >>> 16;
      default: v = (v >>> 50) * (64'sd1 <<< SHIFT) + (64'sd1 <<< (SHIFT - 1));
    endcase
    return v;
  endfunction

  // Monitor: pops one expectation per transfer and checks Y holds while stalled.
  logic [OW-1:0] y_prev;
  bit hold_prev = 0;
  always @(negedge CLK) begin
    if (hold_prev && YV) check("y_stable", longint'(Y), longint'(y_prev));
    hold_prev = RSTN && YV && !(CE && YRDY);
    y_prev = Y;
    if (RSTN && CE && YV && YRDY) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_y: got 0x%0h with no expected value queued", Y);
      end else begin
        check("scoreboard_y", longint'(Y), longint'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    RSTN = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RSTN = 1'b1;
    check("rst_y", longint'(Y), 0);
    check("rst_yv", longint'(YV), 0);
    check("rst_ovf", longint'(OVF), 0);
    check("rst_lost", longint'(LOST), 0);
    check("rst_err", longint'(ERR), 0);

    // Single partial: Y=3 exactly three edges after the completing PV, for one cycle.
    send(3 * (64'sd1 <<< 17), 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check($sformatf("latency_yv_%0d", i), longint'(YV), (i == 3) ? 1 : 0);
      if (i == 3) check("latency_y", longint'(Y), 3);
    end
    @(posedge CLK); #1;

    send(64'sd1 <<< 16, 1, 0);
    wait_y("tie_half", TIE_HALF);
    send(3 * (64'sd1 <<< 16), 1, 0);
    wait_y("tie_three_halves", 2);

    for (int i = 0; i < 4; i++) send((64'sd1 <<< 47) - 1, i == 3, 0);
    wait_y("sat_pos", 24'h7FFFFF);
    check("sat_pos_ovf", longint'(OVF), 1);
    send(-(64'sd1 <<< 47), 1, 0);
    wait_y("sat_neg", 24'h800000);
    pulse_clrf();
    check("ovf_cleared", longint'(OVF), 0);

    // CLRF lands on the same edge that would set OVF.
    send(-(64'sd1 <<< 47), 1, 0);
    idle(1);
    CLRF = 1'b1; @(posedge CLK); #1; CLRF = 1'b0;
    check("clrf_priority", longint'(OVF), 0);
    wait_y("clrf_priority_y", 24'h800000);
    model_ovf = 0;

    // Backpressure: the second result is dropped behind the held first.
    YRDY = 1'b0;
    send(5 * (64'sd1 <<< 17), 1, 0);
    send(7 * (64'sd1 <<< 17), 1, 0);
    void'(exp_q.pop_back());
    idle(6);
    check("bp_yv", longint'(YV), 1);
    check("bp_y_held", longint'(Y), 5);
    check("bp_lost", longint'(LOST), 1);
    YRDY = 1'b1;
    wait_y("bp_first", 5);
    pulse_clrf();
    check("lost_cleared", longint'(LOST), 0);

    for (int i = 0; i < 17; i++) send(64'sd1 <<< 17, i == 16, 0);
    wait_y("overrun_16", 16);
    wait_y("overrun_fresh", 1);
    check("overrun_err", longint'(ERR), 1);
    pulse_clrf();
    check("err_cleared", longint'(ERR), 0);

    // Reset between partials 2 and 3 discards the partial sum.
    send(9 * (64'sd1 <<< 17), 0, 0);
    send(9 * (64'sd1 <<< 17), 0, 0);
    RSTN = 1'b0; @(posedge CLK); #1; RSTN = 1'b1;
    samp_cnt = 0;
    check("mid_rst_yv", longint'(YV), 0);
    send(2 * (64'sd1 <<< 17), 1, 0);
    wait_y("post_reset", 2);

    // Random samples with random CE, back-to-back or with short gaps.
    pulse_clrf();
    for (int s = 0; s < 60; s++) begin
      int len = $urandom_range(1, 17);
      if (len == 17) for (int k = 0; k < 16; k++) send(rand_p(), 0, 1);
      else for (int k = 0; k < len; k++) send(rand_p(), k == len - 1, 1);
      idle($urandom_range(0, 2));
    end
    drain("rand_ce_drain", 0);
    check("rand_ovf", longint'(OVF), longint'(model_ovf));
    check("rand_err", longint'(ERR), longint'(model_err));
    check("rand_lost", longint'(LOST), 0);

    // Random YRDY stalls, one sample in flight at a time.
    for (int s = 0; s < 20; s++) begin
      int len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        YRDY = $urandom_range(0, 1);
        send(rand_p(), k == len - 1, 0);
      end
      drain($sformatf("rand_rdy_drain_%0d", s), 1);
    end
    check("rand_rdy_lost", longint'(LOST), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_accum_round.md
FIR_ACCUM_ROUND -- requirements
Module: fir_accum_round

Interface
REQ-001 The block SHALL have parameter OW, default 24, meaning output sample width in bits (valid range 8..32).
REQ-002 The block SHALL have parameter SHIFT, default 17, meaning the right-shift (scaling) applied to the accumulated sum (valid range 1..40).
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all registers update on its rising edge.
REQ-004 The block SHALL have port RSTN, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port CE, input, 1 bit: clock enable gating every register except reset.
REQ-006 The block SHALL have port P, input, 48 bits: signed partial sum from the upstream quad multiply-add chain.
REQ-007 The block SHALL have port PV, input, 1 bit: P is valid this cycle.
REQ-008 The block SHALL have port PLAST, input, 1 bit: qualified by PV; marks the final partial of one output sample.
REQ-009 The block SHALL have port Y, output, OW bits: signed rounded and saturated output sample.
REQ-010 The block SHALL have port YV, output, 1 bit: Y is valid.
REQ-011 The block SHALL have port YRDY, input, 1 bit: downstream accepts Y.
REQ-012 The block SHALL have port OVF, output, 1 bit: sticky saturation flag.
REQ-013 The block SHALL have port LOST, output, 1 bit: sticky flag indicating a result was dropped by backpressure.
REQ-014 The block SHALL have port ERR, output, 1 bit: sticky flag indicating a partial-count overrun.
REQ-015 The block SHALL have port CLRF, input, 1 bit: clears OVF, LOST and ERR.

Function
REQ-016 The block SHALL hold a 52-bit signed accumulator: the first PV after reset or after a completed sample loads sign-extended P; each subsequent PV adds sign-extended P.
REQ-017 The block SHALL count partials in a 4-bit counter; the counter resets to 0 on sample completion.
REQ-018 A sample SHALL complete on PV&PLAST, or on the 16th PV without PLAST, which additionally sets ERR.
REQ-019 On completion, stage 2 SHALL register the final sum plus the rounding constant, computed in 53 bits, then arithmetic-shift it right by SHIFT (round half up).
REQ-020 Stage 3 SHALL saturate the stage-2 result to OW bits (max 2^(OW-1)-1, min -2^(OW-1)), setting OVF whenever clamping occurs.
REQ-021 Latency SHALL be exactly 3 CE-qualified cycles from the completing PV edge to Y/YV loaded.
REQ-022 A transfer SHALL occur on a CE edge with YV&YRDY; YV then clears unless a new result loads on the same edge, in which case YV stays 1 and Y takes the new value.
REQ-023 If stage 3 loads while YV=1 and YRDY=0, the new result SHALL be discarded, Y/YV SHALL be unchanged, and LOST SHALL be set.
REQ-024 Y SHALL remain stable while YV=1 and no transfer occurs.
REQ-025 When CE=0 the block SHALL perform no state change; PV and YRDY are ignored.
REQ-026 CLRF SHALL win over a same-cycle set of any sticky flag (clear-priority).
REQ-027 A PV arriving in the cycle after a completion SHALL start a new sample with no bubble.

Reset
REQ-028 While RSTN=0 at a clock edge, regardless of CE, the accumulator, counter, pipeline valids, Y, YV, OVF, LOST and ERR SHALL all become 0.
REQ-029 A reset asserted mid-sample SHALL discard the partial sum and any in-flight result.

Configuration
REQ-030 With macro FIR_ACC_CONVERGENT_EN defined, stage 2 SHALL use round-half-to-even: an exact tie rounds to the even quotient.
REQ-031 Without FIR_ACC_CONVERGENT_EN defined, stage 2 SHALL use round half up; latency is identical in both cases.

Verification (OW=24, SHIFT=17, CE=1, YRDY=1 unless stated)
REQ-032 Single partial P=3*2^17 with PLAST -> Y=3, YV high exactly 3 cycles later for 1 cycle.
REQ-033 Rounding ties: P=2^16 -> Y=1 (macro off) / Y=0 (macro on); P=3*2^16 -> Y=2 in both builds.
REQ-034 Saturation: 4 partials of 2^47-1, PLAST on the 4th -> Y=0x7FFFFF, OVF=1; a single partial -2^47 -> Y=0x800000.
REQ-035 Backpressure: YRDY=0, two samples completing 1 cycle apart -> Y holds the first value, LOST=1; CLRF -> LOST=0.
REQ-036 Overrun: 16 PV of P=2^17 without PLAST -> Y=16, ERR=1; the 17th PV starts a fresh sample.
REQ-037 RSTN=0 pulsed between partials 2 and 3 of a sample -> no YV produced; the following sample computes correctly from 0.
